// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package fifo_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;

   localparam int ARB_NUM_REQ    = 4;
   localparam int ARB_MAX_BURST  = 4;
   localparam int ARB_DATA_WIDTH = 8;

   // Producer index reached by stepping 'step' places past 'base', wrapping at n.
   function automatic int rr_next(input int base, input int step, input int n);
      return (base + step) % n;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_select.sv
// Rotating-priority encoder: first set request after last_gnt, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to take the selection.
module rr_select
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = ARB_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_gnt,
   output logic               sel_valid,
   output logic [ID_W-1:0]    sel_id
);

   int idx;

   // Scan last_gnt+1 .. last_gnt+NUM_REQ so the previous winner has lowest priority.
   always_comb begin
      sel_valid = 1'b0;
      sel_id    = '0;
      idx       = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = rr_next(int'(last_gnt), i, NUM_REQ);
         if (!sel_valid && req[idx]) begin
            sel_valid = 1'b1;
            sel_id    = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the FIFO write port; a grant carries up to MAX_BURST words.
// Latency: grant one edge after req seen in IDLE; first write in the granted cycle.
// Backpressure: full stalls the burst in place (no ack, no w_en); grant is never timed out.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = ARB_NUM_REQ,
   parameter int DATA_WIDTH = ARB_DATA_WIDTH,
   parameter int MAX_BURST  = ARB_MAX_BURST
) (
   input  logic                          wclk,
   input  logic                          wrst,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   input  logic                          full,
   output logic                          w_en,
   output logic [DATA_WIDTH-1:0]         data_in,
   output logic                          gnt_valid,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_id
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   arb_state_t        state, state_nxt;
   logic [ID_W-1:0]   gnt_nxt;
   logic [ID_W-1:0]   last_gnt, last_nxt;
   logic [CNT_W-1:0]  burst_cnt, cnt_nxt;

   logic              sel_valid;
   logic [ID_W-1:0]   sel_id;
   logic              req_gnt;
   logic [DATA_WIDTH-1:0] data_sel;
   logic              accept;
   logic              last_word;

   rr_select #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_select (
      .req       (req),
      .last_gnt  (last_gnt),
      .sel_valid (sel_valid),
      .sel_id    (sel_id)
   );

   // Pick out the granted producer's request bit and word.
   always_comb begin
      req_gnt  = 1'b0;
      data_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_id == ID_W'(i)) begin
            req_gnt  = req[i];
            data_sel = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Write-side outputs; wrst blocks the write so an interrupted word stays with its producer.
   always_comb begin
      accept    = (state == BURST) && req_gnt && !full && !wrst;
      w_en      = accept;
      gnt_valid = (state == BURST);
      data_in   = (state == BURST) ? data_sel : '0;
      last_word = (burst_cnt == CNT_W'(MAX_BURST - 1));
      ack       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ack[i] = accept && (gnt_id == ID_W'(i));
      end
   end

   // Next-state: take a new grant from IDLE, end a burst on its last word or on release.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt_id;
      last_nxt  = last_gnt;
      cnt_nxt   = burst_cnt;
      case (state)
         IDLE: begin
            if (sel_valid) begin
               state_nxt = BURST;
               gnt_nxt   = sel_id;
               cnt_nxt   = '0;
            end
         end
         BURST: begin
            if (!req_gnt) begin
               state_nxt = IDLE;
               last_nxt  = gnt_id;
            end else if (accept) begin
               cnt_nxt = burst_cnt + CNT_W'(1);
               if (last_word) begin
                  state_nxt = IDLE;
                  last_nxt  = gnt_id;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State registers; last_gnt resets to the top index so producer 0 wins first.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state     <= IDLE;
         gnt_id    <= '0;
         last_gnt  <= ID_W'(NUM_REQ - 1);
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         gnt_id    <= gnt_nxt;
         last_gnt  <= last_nxt;
         burst_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for the FIFO write-port arbiter: per-cycle hand-computed outputs.
// Latency: inputs change on the falling edge, outputs are compared 1 ns later.
// Backpressure: full is driven directly to exercise stalls.
module tb_fifo_write_arbiter;

   logic        wclk;
   logic        wrst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        full;
   logic        w_en;
   logic [7:0]  data_in;
   logic        gnt_valid;
   logic [1:0]  gnt_id;

   logic [7:0]  pd [4];

   int errors = 0;
   int checks = 0;

   assign req_data = {pd[3], pd[2], pd[1], pd[0]};

   fifo_write_arbiter #(
      .NUM_REQ    (4),
      .DATA_WIDTH (8),
      .MAX_BURST  (4)
   ) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .req       (req),
      .req_data  (req_data),
      .ack       (ack),
      .full      (full),
      .w_en      (w_en),
      .data_in   (data_in),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare all outputs for the current cycle, then move to the next falling edge.
   task automatic cyc(input string tag, input logic ew, input logic [3:0] ea,
                      input logic [7:0] ed, input logic ev, input logic [1:0] eg);
      #1;
      check({tag, ".w_en"},      32'(w_en),      32'(ew));
      check({tag, ".ack"},       32'(ack),       32'(ea));
      check({tag, ".data_in"},   32'(data_in),   32'(ed));
      check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(ev));
      check({tag, ".gnt_id"},    32'(gnt_id),    32'(eg));
      @(negedge wclk);
   endtask

   task automatic idle_cyc(input string tag, input logic [1:0] eg);
      cyc(tag, 1'b0, 4'b0000, 8'h00, 1'b0, eg);
   endtask

   task automatic write_cyc(input string tag, input logic [1:0] g, input logic [7:0] d);
      cyc(tag, 1'b1, 4'(1) << g, d, 1'b1, g);
   endtask

   task automatic stall_cyc(input string tag, input logic [1:0] g, input logic [7:0] d);
      cyc(tag, 1'b0, 4'b0000, d, 1'b1, g);
   endtask

   task automatic do_reset();
      req  = 4'b0000;
      full = 1'b0;
      wrst = 1'b1;
      @(negedge wclk);
      wrst = 1'b0;
   endtask

   initial begin
      int gl [5];
      logic [1:0] prev;
      gl = '{0, 1, 2, 3, 0};

      wrst = 1'b1;
      req  = 4'b0000;
      full = 1'b0;
      for (int i = 0; i < 4; i++) pd[i] = 8'h00;
      repeat (2) @(negedge wclk);

      // Reset values
      cyc("reset", 1'b0, 4'b0000, 8'h00, 1'b0, 2'd0);
      wrst = 1'b0;

      // Single producer: two bursts of 4 separated by one bubble
      req   = 4'b0001;
      pd[0] = 8'h10;
      idle_cyc("t1.arb", 2'd0);
      for (int k = 0; k < 8; k++) begin
         pd[0] = 8'(8'h10 + k);
         if (k == 4) idle_cyc("t1.bubble", 2'd0);
         write_cyc("t1.wr", 2'd0, 8'(8'h10 + k));
      end
      req = 4'b0000;
      idle_cyc("t1.end", 2'd0);

      // All four requesting: grants 0,1,2,3,0 of 4 words each
      do_reset();
      req  = 4'b1111;
      prev = 2'd0;
      for (int b = 0; b < 5; b++) begin
         pd[gl[b]] = 8'(8'h20 + b*8);
         idle_cyc("t2.bubble", prev);
         for (int n = 0; n < 4; n++) begin
            pd[gl[b]] = 8'(8'h20 + b*8 + n);
            write_cyc("t2.wr", 2'(gl[b]), 8'(8'h20 + b*8 + n));
         end
         prev = 2'(gl[b]);
      end
      req = 4'b0000;
      idle_cyc("t2.end", 2'd0);

      // Full stall in the middle of producer 2's burst
      do_reset();
      req   = 4'b0100;
      pd[2] = 8'h30;
      idle_cyc("t3.arb", 2'd0);
      write_cyc("t3.wr0", 2'd2, 8'h30);
      pd[2] = 8'h31;
      write_cyc("t3.wr1", 2'd2, 8'h31);
      pd[2] = 8'h32;
      full  = 1'b1;
      for (int s = 0; s < 3; s++) stall_cyc("t3.stall", 2'd2, 8'h32);
      full = 1'b0;
      write_cyc("t3.wr2", 2'd2, 8'h32);
      pd[2] = 8'h33;
      write_cyc("t3.wr3", 2'd2, 8'h33);
      req = 4'b0000;
      idle_cyc("t3.end", 2'd2);

      // Early release by producer 1; next grant rotates to producer 2
      do_reset();
      req   = 4'b0110;
      pd[1] = 8'h40;
      pd[2] = 8'h50;
      idle_cyc("t4.arb", 2'd0);
      write_cyc("t4.wr0", 2'd1, 8'h40);
      pd[1] = 8'h41;
      write_cyc("t4.wr1", 2'd1, 8'h41);
      pd[1] = 8'h42;
      req   = 4'b0100;
      stall_cyc("t4.drop", 2'd1, 8'h42);
      req = 4'b0110;
      idle_cyc("t4.idle", 2'd1);
      write_cyc("t4.p2", 2'd2, 8'h50);
      req   = 4'b0000;
      pd[2] = 8'h51;
      stall_cyc("t4.drop2", 2'd2, 8'h51);
      idle_cyc("t4.end", 2'd2);

      // Reset during producer 3's third word
      do_reset();
      req   = 4'b1000;
      pd[3] = 8'h60;
      idle_cyc("t5.arb", 2'd0);
      write_cyc("t5.wr0", 2'd3, 8'h60);
      pd[3] = 8'h61;
      write_cyc("t5.wr1", 2'd3, 8'h61);
      pd[3] = 8'h62;
      pd[0] = 8'h70;
      req   = 4'b1001;
      wrst  = 1'b1;
      cyc("t5.rst", 1'b0, 4'b0000, 8'h62, 1'b1, 2'd3);
      wrst = 1'b0;
      idle_cyc("t5.after", 2'd0);
      for (int n = 0; n < 4; n++) begin
         pd[0] = 8'(8'h70 + n);
         write_cyc("t5.p0", 2'd0, 8'(8'h70 + n));
      end
      req = 4'b1000;
      idle_cyc("t5.bubble", 2'd0);
      write_cyc("t5.redo", 2'd3, 8'h62);
      pd[3] = 8'h63;
      write_cyc("t5.wr3", 2'd3, 8'h63);
      req   = 4'b0000;
      pd[3] = 8'h64;
      stall_cyc("t5.rel", 2'd3, 8'h64);
      idle_cyc("t5.end", 2'd3);

      // Non-contiguous requests 4'b1010 from reset: 1, then 3, then 1
      do_reset();
      req   = 4'b1010;
      pd[1] = 8'h80;
      pd[3] = 8'h90;
      idle_cyc("t6.arb", 2'd0);
      for (int n = 0; n < 4; n++) begin
         pd[1] = 8'(8'h80 + n);
         write_cyc("t6.p1", 2'd1, 8'(8'h80 + n));
      end
      pd[1] = 8'h84;
      idle_cyc("t6.bubble1", 2'd1);
      for (int n = 0; n < 4; n++) begin
         pd[3] = 8'(8'h90 + n);
         write_cyc("t6.p3", 2'd3, 8'(8'h90 + n));
      end
      idle_cyc("t6.bubble3", 2'd3);
      write_cyc("t6.p1b", 2'd1, 8'h84);
      req   = 4'b0000;
      pd[1] = 8'h85;
      stall_cyc("t6.rel", 2'd1, 8'h85);
      idle_cyc("t6.end", 2'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
